// File: rtl/tv80_arb_pkg.sv
// Shared types and constants for the TV80 bus arbiter: FSM encoding,
// bus_owner select codes and the default grant timeout.
package tv80_arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      GRANT   = 3'd2,
      HANDOFF = 3'd3,
      RELEASE = 3'd4
   } arb_state_t;

   localparam logic [1:0] OWNER_CPU  = 2'd0;
   localparam logic [1:0] OWNER_REQ0 = 2'd1;
   localparam logic [1:0] OWNER_REQ1 = 2'd2;

   localparam logic [7:0] TIMEOUT_DEFAULT = 8'd200;

   // Map a one-hot winner onto the bus-mux select code.
   function automatic logic [1:0] owner_of(input logic [1:0] onehot);
      if (onehot[1])      return OWNER_REQ1;
      else if (onehot[0]) return OWNER_REQ0;
      else                return OWNER_CPU;
   endfunction

endpackage

// File: rtl/tv80_bus_arbiter_if.sv
// Bus-side signal bundle of the arbiter: external requests/grants, the TV80
// BUSRQ/BUSAK pair, the bus-mux select and the timeout pulse.
interface tv80_bus_arbiter_if;
   logic [1:0] req;
   logic [1:0] gnt;
   logic       cpu_busrq_n;
   logic       cpu_busak_n;
   logic [1:0] bus_owner;
   logic       timeout_err;

   // Handshake: req is a level held by a master until it is done with the bus;
   // gnt[w] is valid only while the CPU acknowledges (cpu_busak_n low) the
   // request raised by cpu_busrq_n, and a master may drive the bus only when
   // its gnt bit is high. Dropping req ends the tenure.
   modport master (
      input  req,
      input  cpu_busak_n,
      output gnt,
      output cpu_busrq_n,
      output bus_owner,
      output timeout_err
   );

   modport slave (
      output req,
      output cpu_busak_n,
      input  gnt,
      input  cpu_busrq_n,
      input  bus_owner,
      input  timeout_err
   );
endinterface

// File: rtl/tv80_arb_rr.sv
// Two-way round-robin winner select: a tie goes to the requester that was
// not served last; a lone request always wins.
module tv80_arb_rr (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_win
);

   always_comb begin
      o_win = 2'b00;
      case (i_req)
         2'b01:   o_win = 2'b01;
         2'b10:   o_win = 2'b10;
         2'b11:   o_win = i_last ? 2'b01 : 2'b10;
         default: o_win = 2'b00;
      endcase
   end

endmodule

// File: rtl/tv80_bus_arbiter.sv
// Arbitrates two external bus masters against the TV80 core via BUSRQ/BUSAK.
// Optional grant timeout is compiled in with `define TV80_ARB_TIMEOUT_EN.
module tv80_bus_arbiter
   import tv80_arb_pkg::*;
#(
   parameter logic [7:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                reset_n,
   tv80_bus_arbiter_if.master  bus,
   output arb_state_t          o_state
);

   arb_state_t r_state;
   logic [1:0] r_gnt;
   logic       r_busrq_n;
   logic [1:0] r_owner;
   logic       r_last;
   logic       r_tmo_err;

   logic [1:0] w_req_eff;
   logic [1:0] w_win;
   logic       w_tmo_hit;
   logic       w_hold;

`ifdef TV80_ARB_TIMEOUT_EN
   logic [7:0] r_tmo_cnt;
   logic [1:0] r_mask;

   // A timed-out requester stays masked until it lets go of req.
   assign w_req_eff = bus.req & ~r_mask;
   assign w_tmo_hit = (r_state == GRANT) &&
                      ((r_tmo_cnt + 8'd1) == TIMEOUT_CYCLES) &&
                      (|(bus.req & r_gnt));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_tmo_cnt <= 8'd0;
         r_mask    <= 2'b00;
      end else begin
         r_tmo_cnt <= (r_state == GRANT) ? r_tmo_cnt + 8'd1 : 8'd0;
         if (w_tmo_hit && !bus.cpu_busak_n)
            r_mask <= (r_mask & bus.req) | r_gnt;
         else
            r_mask <= r_mask & bus.req;
      end
   end
`else
   logic w_unused_tmo;

   assign w_req_eff    = bus.req;
   assign w_tmo_hit    = 1'b0;
   assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

   tv80_arb_rr u_rr (
      .i_req  (w_req_eff),
      .i_last (r_last),
      .o_win  (w_win)
   );

   assign w_hold = (|(w_req_eff & r_gnt)) && !w_tmo_hit;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_gnt     <= 2'b00;
         r_busrq_n <= 1'b1;
         r_owner   <= OWNER_CPU;
         r_last    <= 1'b1;
         r_tmo_err <= 1'b0;
      end else begin
         r_tmo_err <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (|w_req_eff) begin
                  r_state   <= REQ;
                  r_busrq_n <= 1'b0;
               end
            end
            REQ: begin
               if (!bus.cpu_busak_n) begin
                  if (|w_req_eff) begin
                     r_state <= GRANT;
                     r_gnt   <= w_win;
                     r_owner <= owner_of(w_win);
                     r_last  <= w_win[1];
                  end else begin
                     r_state   <= RELEASE;
                     r_busrq_n <= 1'b1;
                     r_owner   <= OWNER_CPU;
                  end
               end
            end
            GRANT: begin
               // Losing BUSAK mid-tenure means the CPU took the bus back.
               if (bus.cpu_busak_n) begin
                  r_state   <= RELEASE;
                  r_gnt     <= 2'b00;
                  r_busrq_n <= 1'b1;
                  r_owner   <= OWNER_CPU;
               end else if (!w_hold) begin
                  r_state   <= HANDOFF;
                  r_gnt     <= 2'b00;
                  r_tmo_err <= w_tmo_hit;
               end
            end
            HANDOFF: begin
               if (!bus.cpu_busak_n && (|w_req_eff)) begin
                  r_state <= GRANT;
                  r_gnt   <= w_win;
                  r_owner <= owner_of(w_win);
                  r_last  <= w_win[1];
               end else begin
                  r_state   <= RELEASE;
                  r_busrq_n <= 1'b1;
                  r_owner   <= OWNER_CPU;
               end
            end
            RELEASE: begin
               if (bus.cpu_busak_n)
                  r_state <= IDLE;
            end
            default: begin
               r_state   <= IDLE;
               r_gnt     <= 2'b00;
               r_busrq_n <= 1'b1;
               r_owner   <= OWNER_CPU;
            end
         endcase
      end
   end

   assign bus.gnt         = r_gnt;
   assign bus.cpu_busrq_n = r_busrq_n;
   assign bus.bus_owner   = r_owner;
   assign bus.timeout_err = r_tmo_err;
   assign o_state         = r_state;

endmodule

// File: doc/tv80_bus_arbiter.md
TV80_BUS_ARBITER -- requirements
Module: tv80_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8'd200, maximum grant hold in cycles when the timeout is compiled in; legal range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 req  input  2  external master bus requests, active-high, level; bit 0 = requester 0, bit 1 = requester 1.
REQ-005 gnt  output  2  bus grants, active-high, registered, at most one bit set.
REQ-006 cpu_busrq_n  output  1  bus request to the TV80 core, active-low, registered.
REQ-007 cpu_busak_n  input  1  bus acknowledge from the TV80 core, active-low.
REQ-008 bus_owner  output  2  registered bus-mux select: 0 = CPU, 1 = requester 0, 2 = requester 1; value 3 is never driven.
REQ-009 timeout_err  output  1  one-cycle pulse on a forced grant revocation.

Function
REQ-010 The FSM SHALL have exactly five states: IDLE, REQ, GRANT, HANDOFF and RELEASE.
REQ-011 In IDLE, cpu_busrq_n=1, gnt=0 and bus_owner=0.
  - If any req bit is sampled high, the FSM SHALL enter REQ.
  - cpu_busrq_n SHALL go low in the same edge (1-cycle latency).
REQ-012 In REQ, cpu_busrq_n SHALL stay low until cpu_busak_n is sampled low.
  - If a req bit is then high, the FSM SHALL enter GRANT.
  - Otherwise the FSM SHALL enter RELEASE.
REQ-013 GRANT entry SHALL set gnt[w]=1 and bus_owner=w+1 in the same edge, where w is the round-robin winner among the requests sampled at that edge.
REQ-014 Round-robin rule: the requester not served last SHALL win a tie; after reset, requester 0 SHALL win a tie.
REQ-015 In GRANT, the grant SHALL hold while req[w] is high; req[w] sampled low SHALL send the FSM to HANDOFF.
REQ-016 HANDOFF SHALL last exactly one cycle with gnt=0 and bus_owner unchanged; cpu_busrq_n SHALL remain low.
REQ-017 From HANDOFF:
  - any pending req SHALL send the FSM to GRANT using the REQ-013/014 rules;
  - otherwise the FSM SHALL enter RELEASE.
REQ-018 RELEASE SHALL drive cpu_busrq_n=1 and bus_owner=0.
  - The FSM SHALL wait for cpu_busak_n sampled high, then enter IDLE.
  - Requests SHALL be ignored until IDLE is reached.
REQ-019 The arbiter SHALL never drive gnt high unless cpu_busak_n was sampled low in the cycle that entered or sustained bus ownership.
REQ-020 If cpu_busak_n rises during GRANT (protocol violation), the FSM SHALL drop gnt and enter RELEASE on the next edge.
REQ-021 A requester that re-asserts req in the HANDOFF cycle SHALL be regranted only if the other requester is not pending.

Reset
REQ-022 While reset_n is sampled low, outputs SHALL be cpu_busrq_n=1, gnt=0, bus_owner=0, timeout_err=0; the FSM SHALL be IDLE, the round-robin pointer SHALL favour requester 0, and the timeout counter and mask SHALL be cleared.
REQ-023 Reset asserted mid-GRANT SHALL drop gnt and cpu_busrq_n at the same edge, with no HANDOFF cycle.

Configuration
REQ-024 Macro TV80_ARB_TIMEOUT_EN, when defined, SHALL enable the grant timeout:
  - an 8-bit counter SHALL clear on GRANT entry and increment each GRANT cycle;
  - when it equals TIMEOUT_CYCLES with req[w] still high, the FSM SHALL enter HANDOFF and pulse timeout_err for one cycle;
  - req[w] SHALL be masked until it is sampled low.
REQ-025 With TV80_ARB_TIMEOUT_EN undefined, no counter or mask SHALL exist, timeout_err SHALL be tied 0, and grants SHALL be unbounded.

Structure
REQ-026 Shared package tv80_arb_pkg SHALL hold the FSM state encoding, the bus_owner constants (OWNER_CPU, OWNER_REQ0, OWNER_REQ1) and the default timeout constant.
REQ-027 The round-robin winner selection SHALL be a combinational sub-module, tv80_arb_rr (inputs: request vector, last-served pointer; output: one-hot winner).

Verification
REQ-028 req=01 at cycle 0, busak_n low at cycle 3:
  - cpu_busrq_n=0 from cycle 1;
  - gnt=01 and bus_owner=1 from cycle 4;
  - req drop at cycle 10 -> gnt=00 at cycle 11 (HANDOFF) -> cpu_busrq_n=1 at cycle 12.
REQ-029 req=11 simultaneously after reset:
  - requester 0 is granted first;
  - req[0] drops -> one HANDOFF cycle with gnt=00 -> gnt=10 and bus_owner=2, with no CPU release in between.
REQ-030 req=01 pulses for 1 cycle, then drops before busak_n goes low -> no grant; RELEASE, cpu_busrq_n=1, IDLE after busak_n returns high.
REQ-031 reset_n low during GRANT (gnt=10) -> next edge gives gnt=00, cpu_busrq_n=1, bus_owner=0; next tie after reset goes to requester 0.
REQ-032 With TV80_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, req=01 held high:
  - gnt[0] drops after 4 GRANT cycles with a single timeout_err pulse;
  - no regrant to requester 0 until req[0] is cycled low and high.
REQ-033 cpu_busak_n forced high during GRANT -> gnt=00 next edge, FSM in RELEASE, never a cycle with gnt!=0 and busak_n high beyond one edge.
